// File: rtl/block1_pkg.sv
// Shared defaults and types for the block1 overflow timer.
package block1_pkg;

  localparam int unsigned DIV_DEF   = 50_000;
  localparam int unsigned TOP_DEF   = 999;
  localparam int unsigned CNT_W_DEF = 32;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/block1_tick_div.sv
// Prescaler: emits a single-cycle tick every DIV clocks, counting 0..DIV-1.
module block1_tick_div
  import block1_pkg::*;
#(
  parameter int unsigned DIV   = DIV_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic CLOCK_50,
  input  logic KEY0,
  output logic tick
);

  logic [CNT_W-1:0] pre;

  // Tick is combinational so the main counter advances on the same edge the prescaler wraps.
  assign tick = (pre == CNT_W'(DIV - 1));

  always_ff @(posedge CLOCK_50) begin
    if (KEY0 || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + CNT_W'(1);
    end
  end

endmodule

// File: rtl/block1_ovf_counter.sv
// Two-stage free-running timer: prescaler tick feeds a 0..TOP counter whose wrap drives ovrflow/pin_name1.
// Build option: define BLOCK1_STICKY_OVF_EN to make ovrflow hold after the first wrap until KEY0.
module block1_ovf_counter
  import block1_pkg::*;
#(
  parameter int unsigned DIV   = DIV_DEF,
  parameter int unsigned TOP   = TOP_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic CLOCK_50,
  input  logic KEY0,
  output logic ovrflow,
  output logic pin_name1
);

  logic             tick;
  logic [CNT_W-1:0] cnt;
  logic             wrap_c;

  block1_tick_div #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_tick_div (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .tick     (tick)
  );

  assign wrap_c = tick && (cnt == CNT_W'(TOP));

  // Main counter plus the wrap-event registers; KEY0 overrides every event.
  always_ff @(posedge CLOCK_50) begin
    if (KEY0) begin
      cnt       <= '0;
      ovrflow   <= 1'b0;
      pin_name1 <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
      end
`ifdef BLOCK1_STICKY_OVF_EN
      ovrflow <= ovrflow | wrap_c;
`else
      ovrflow <= wrap_c;
`endif
      pin_name1 <= pin_name1 ^ wrap_c;
    end
  end

endmodule

// File: tb/tb_block1_ovf_counter.sv
// Scoreboard bench: two timer instances (DIV=4/TOP=9 and DIV=1/TOP=1) against an edge-count model.
module tb_block1_ovf_counter;

  localparam int unsigned DIV_A = 4;
  localparam int unsigned TOP_A = 9;
  localparam int unsigned DIV_B = 1;
  localparam int unsigned TOP_B = 1;
  localparam int PER_A = DIV_A * (TOP_A + 1);
  localparam int PER_B = DIV_B * (TOP_B + 1);

  logic clk = 1'b0;
  logic key = 1'b1;
  logic ovf_a, pin_a, ovf_b, pin_b;

  typedef struct {
    logic ovf_a;
    logic pin_a;
    logic ovf_b;
    logic pin_b;
    int   cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_edges  = 0;
  int   cyc      = 0;
  bit   started  = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #2 clk = ~clk;

  block1_ovf_counter #(.DIV(DIV_A), .TOP(TOP_A), .CNT_W(8)) u_dut_a (
    .CLOCK_50  (clk),
    .KEY0      (key),
    .ovrflow   (ovf_a),
    .pin_name1 (pin_a)
  );

  block1_ovf_counter #(.DIV(DIV_B), .TOP(TOP_B), .CNT_W(4)) u_dut_b (
    .CLOCK_50  (clk),
    .KEY0      (key),
    .ovrflow   (ovf_b),
    .pin_name1 (pin_b)
  );

  // Expected outputs after n rising edges since reset release, for wrap period p.
  function automatic logic model_ovf(input int n, input int p);
`ifdef BLOCK1_STICKY_OVF_EN
    return (n >= p);
`else
    return (n != 0) && ((n % p) == 0);
`endif
  endfunction

  function automatic logic model_pin(input int n, input int p);
    return ((n / p) % 2) == 1;
  endfunction

  // Drive KEY0 away from the active edge and queue what the next edge must produce.
  task automatic step(input logic k);
    exp_t e;
    @(negedge clk);
    key = k;
    n_edges = k ? 0 : n_edges + 1;
    cyc++;
    e.ovf_a = model_ovf(n_edges, PER_A);
    e.pin_a = model_pin(n_edges, PER_A);
    e.ovf_b = model_ovf(n_edges, PER_B);
    e.pin_b = model_pin(n_edges, PER_B);
    e.cyc   = cyc;
    exp_q.push_back(e);
    started = 1'b1;
  endtask

  task automatic run(input logic k, input int cycles);
    for (int i = 0; i < cycles; i++) step(k);
  endtask

  task automatic chk(input string name, input int c, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, exp);
    end
  endtask

  // Monitor: pop one expectation per edge and compare the sampled outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ovrflow_a",   e.cyc, ovf_a, e.ovf_a);
        chk("pin_name1_a", e.cyc, pin_a, e.pin_a);
        chk("ovrflow_b",   e.cyc, ovf_b, e.ovf_b);
        chk("pin_name1_b", e.cyc, pin_b, e.pin_b);
      end else if (started) begin
        n_checks++;
        n_fails++;
        $display("FAIL scoreboard_underflow: got empty queue expected an entry");
      end
    end
  end

  initial begin
    run(1'b1, 3);                 // hold in reset
    run(1'b0, 205);               // free run: wraps at 40,80,...,200
    run(1'b0, 20);
    run(1'b1, 1);                 // mid-count reset
    run(1'b0, 130);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
    end
    run(1'b0, 90);
    run(1'b1, 2);                 // sticky/pulse clear check
    run(1'b0, 5);
    @(posedge clk);
    #2;
    started = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
